// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline-stage widths, control-bit indices and kill masks
//   per-stage default DATA_W/CTRL_W, CTRL_* bit positions, *_KILL_MASK bubbles
package pipe_pkg;
    localparam int IFID_DATA_W  = 64;
    localparam int IFID_CTRL_W  = 16;
    localparam int IDEX_DATA_W  = 96;
    localparam int IDEX_CTRL_W  = 16;
    localparam int EXMEM_DATA_W = 96;
    localparam int EXMEM_CTRL_W = 16;
    localparam int MEMWB_DATA_W = 64;
    localparam int MEMWB_CTRL_W = 16;

    localparam int CTRL_MEM_WRITE = 0;
    localparam int CTRL_REG_WRITE = 1;
    localparam int CTRL_BRANCH    = 2;
    localparam int CTRL_JUMP      = 3;
    localparam int CTRL_HALT      = 4;

    function automatic logic [15:0] ctrl_bit(input int idx);
        return 16'(1) << idx;
    endfunction

    // IF/ID carries undecoded control, so a bubble clears all of it
    localparam logic [15:0] IFID_KILL_MASK  = '1;
    localparam logic [15:0] IDEX_KILL_MASK  = ctrl_bit(CTRL_MEM_WRITE) | ctrl_bit(CTRL_REG_WRITE)
                                            | ctrl_bit(CTRL_BRANCH) | ctrl_bit(CTRL_JUMP)
                                            | ctrl_bit(CTRL_HALT);
    localparam logic [15:0] EXMEM_KILL_MASK = ctrl_bit(CTRL_MEM_WRITE) | ctrl_bit(CTRL_REG_WRITE)
                                            | ctrl_bit(CTRL_HALT);
    localparam logic [15:0] MEMWB_KILL_MASK = ctrl_bit(CTRL_REG_WRITE) | ctrl_bit(CTRL_HALT);
endpackage

// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: valid/ready payload channel between pipeline stages
//   valid/ready handshake, data (DATA_W), ctrl (CTRL_W), kill (bubble this transfer)
//   master drives the payload, slave returns ready
interface pipe_stage_skid_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = IDEX_DATA_W,
    parameter int CTRL_W = IDEX_CTRL_W
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    logic              kill;

    modport master (output valid, data, ctrl, kill, input ready);
    modport slave  (input valid, data, ctrl, kill, output ready);
endinterface

// File: rtl/pipe_entry.sv
// pipe_entry: one valid+data+ctrl pipeline slot with load and clear
//   clk/rst, ld (capture d_* and set valid), clr (drop valid, keep payload), valid/data/ctrl out
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int DATA_W = IDEX_DATA_W,
    parameter int CTRL_W = IDEX_CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic              clr,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (ld) begin
            valid <= 1'b1;
            data  <= d_data;
            ctrl  <= d_ctrl;
        end else if (clr) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pipeline register with 2-entry skid buffer, flush, kill and stall counter
//   clk/rst, flush (squash all in flight), up (slave channel in), dn (master channel out),
//   stall_cnt (saturating count of dn.valid && !dn.ready cycles)
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = IDEX_DATA_W,
    parameter int                CTRL_W    = IDEX_CTRL_W,
    parameter logic [CTRL_W-1:0] KILL_MASK = {CTRL_W{1'b1}},
    parameter int                CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    pipe_stage_skid_if.slave   up,
    pipe_stage_skid_if.master  dn,
    output logic [CNT_W-1:0]   stall_cnt
);
    logic              m_v, s_v, rdy;
    logic              in_fire, out_fire, m_ld, m_clr, s_ld, s_clr, s_nxt;
    logic [DATA_W-1:0] m_data, s_data, m_d;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_c, cap_ctrl;

    always_comb begin
        in_fire  = up.valid & rdy;
        out_fire = m_v & dn.ready;
        cap_ctrl = up.kill ? up.ctrl & ~KILL_MASK : up.ctrl;
        // head refills from skid when it holds something, else straight from the input
        m_ld     = !flush & (s_v ? out_fire : in_fire & (!m_v | out_fire));
        m_clr    = flush | out_fire;
        s_ld     = !flush & m_v & !s_v & in_fire & !out_fire;
        s_clr    = flush | out_fire;
        s_nxt    = s_ld | (s_v & !s_clr);
        m_d      = s_v ? s_data : up.data;
        m_c      = s_v ? s_ctrl : cap_ctrl;
    end

    pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_m (
        .clk(clk), .rst(rst), .ld(m_ld), .clr(m_clr), .d_data(m_d), .d_ctrl(m_c),
        .valid(m_v), .data(m_data), .ctrl(m_ctrl)
    );

    pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_s (
        .clk(clk), .rst(rst), .ld(s_ld), .clr(s_clr), .d_data(up.data), .d_ctrl(cap_ctrl),
        .valid(s_v), .data(s_data), .ctrl(s_ctrl)
    );

    // ready tracks the next skid occupancy so it stays a plain flop with no path from dn.ready
    always_ff @(posedge clk) begin
        rdy <= rst ? 1'b0 : !s_nxt;
        if (rst)
            stall_cnt <= '0;
        else if (m_v & !dn.ready & ~&stall_cnt)
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk)
        if (!rst) assert (m_v || !s_v);

    assign up.ready = rdy;
    assign dn.valid = m_v;
    assign dn.data  = m_data;
    assign dn.ctrl  = m_v ? m_ctrl : m_ctrl & ~KILL_MASK;
    assign dn.kill  = 1'b0;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and randomized checks of pipe_stage_skid against a queue model
module tb_pipe_stage_skid;
    import pipe_pkg::*;
    localparam int DW = IDEX_DATA_W;
    localparam int CW = IDEX_CTRL_W;
    localparam logic [CW-1:0] MASK = IDEX_KILL_MASK;

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } item_t;

    logic clk = 1'b0, rst = 1'b0, flush = 1'b0;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt4;

    pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) up_if(), dn_if(), up4(), dn4();

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .KILL_MASK(MASK), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .up(up_if), .dn(dn_if), .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .KILL_MASK(MASK), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .up(up4), .dn(dn4), .stall_cnt(stall_cnt4)
    );

    assign up4.valid = up_if.valid;
    assign up4.data  = up_if.data;
    assign up4.ctrl  = up_if.ctrl;
    assign up4.kill  = up_if.kill;
    assign dn4.ready = dn_if.ready;

    always #5 clk = ~clk;

    item_t q[$];
    int    cnt = 0;
    bit    m_rdy = 1'b0;
    int    errors = 0;
    int    checks = 0;

    function automatic logic [3:0] sat4(input int v);
        return v > 15 ? 4'hF : 4'(v);
    endfunction

    // advance one clock: model a 2-deep FIFO with flush, kill and a saturating stall count
    task automatic tick();
        bit fi, fo;
        item_t it;
        fi   = up_if.valid && m_rdy;
        fo   = q.size() > 0 && dn_if.ready;
        it.d = up_if.data;
        it.c = up_if.kill ? up_if.ctrl & ~MASK : up_if.ctrl;
        @(posedge clk);
        if (rst) begin
            q.delete();
            cnt = 0;
        end else begin
            if (q.size() > 0 && !dn_if.ready && cnt < 65535) cnt++;
            if (flush) q.delete();
            else begin
                if (fo) void'(q.pop_front());
                if (fi) q.push_back(it);
            end
        end
        m_rdy = !rst && q.size() < 2;
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        up_if.valid = 1'b1;
        up_if.data  = d;
        up_if.ctrl  = CW'(d);
        up_if.kill  = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        up_if.valid = 1'b1;
        up_if.data  = '0;
        up_if.ctrl  = '1;
        up_if.kill  = 1'b0;
        dn_if.ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (up_if.ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b exp 0", up_if.ready); end
        checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", dn_if.valid); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall: got %0d exp 0", stall_cnt); end
        checks++; if (stall_cnt4 !== 4'd0) begin errors++; $display("FAIL rst_stall4: got %0d exp 0", stall_cnt4); end
        rst = 1'b0;
        up_if.valid = 1'b0;
        tick();
        checks++; if (up_if.ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b exp 1", up_if.ready); end
        checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid: got %b exp 0", dn_if.valid); end
        checks++; if ((dn_if.ctrl & MASK) !== '0) begin errors++; $display("FAIL post_rst_ctrl_mask: got %h exp 0", dn_if.ctrl & MASK); end
    endtask

    task automatic test_stream();
        dn_if.ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            checks++; if (up_if.ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b exp 1", k, up_if.ready); end
            push(DW'(k));
            checks++;
            if (dn_if.valid !== 1'b1 || dn_if.data !== DW'(k)) begin
                errors++; $display("FAIL stream_out[%0d]: got v=%b d=%h exp v=1 d=%h", k, dn_if.valid, dn_if.data, DW'(k));
            end
        end
        up_if.valid = 1'b0;
        tick();
        checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b exp 0", dn_if.valid); end
    endtask

    task automatic test_stall();
        int s0;
        s0 = cnt;
        dn_if.ready = 1'b0;
        push(DW'('hA));
        checks++; if (dn_if.valid !== 1'b1 || dn_if.data !== DW'('hA)) begin errors++; $display("FAIL stall_head_a: got %h exp a", dn_if.data); end
        checks++; if (up_if.ready !== 1'b1) begin errors++; $display("FAIL stall_ready_one: got %b exp 1", up_if.ready); end
        push(DW'('hB));
        checks++; if (up_if.ready !== 1'b0) begin errors++; $display("FAIL stall_full_ready: got %b exp 0", up_if.ready); end
        checks++; if (stall_cnt !== 16'(s0 + 1)) begin errors++; $display("FAIL stall_cnt1: got %0d exp %0d", stall_cnt, s0 + 1); end
        push(DW'('hC));
        push(DW'('hC));
        checks++; if (up_if.ready !== 1'b0) begin errors++; $display("FAIL stall_held_ready: got %b exp 0", up_if.ready); end
        checks++; if (dn_if.data !== DW'('hA)) begin errors++; $display("FAIL stall_held_head: got %h exp a", dn_if.data); end
        checks++; if (stall_cnt !== 16'(s0 + 3)) begin errors++; $display("FAIL stall_cnt3: got %0d exp %0d", stall_cnt, s0 + 3); end
        dn_if.ready = 1'b1;
        tick();
        checks++; if (dn_if.valid !== 1'b1 || dn_if.data !== DW'('hB)) begin errors++; $display("FAIL stall_order_b: got %h exp b", dn_if.data); end
        checks++; if (up_if.ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b exp 1", up_if.ready); end
        tick();
        checks++; if (dn_if.valid !== 1'b1 || dn_if.data !== DW'('hC)) begin errors++; $display("FAIL stall_order_c: got %h exp c", dn_if.data); end
        up_if.valid = 1'b0;
        tick();
        checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b exp 0", dn_if.valid); end
    endtask

    task automatic test_kill();
        logic [DW-1:0] d;
        d = {$urandom, $urandom, $urandom};
        dn_if.ready = 1'b1;
        up_if.valid = 1'b1;
        up_if.data  = d;
        up_if.ctrl  = 16'hFFFF;
        up_if.kill  = 1'b1;
        tick();
        checks++; if (dn_if.ctrl !== 16'hFFE0) begin errors++; $display("FAIL kill_ctrl: got %h exp ffe0", dn_if.ctrl); end
        checks++; if (dn_if.data !== d) begin errors++; $display("FAIL kill_data: got %h exp %h", dn_if.data, d); end
        up_if.kill = 1'b0;
        tick();
        checks++; if (dn_if.ctrl !== 16'hFFFF) begin errors++; $display("FAIL nokill_ctrl: got %h exp ffff", dn_if.ctrl); end
        up_if.valid = 1'b0;
        tick();
        checks++; if (dn_if.valid !== 1'b0 || (dn_if.ctrl & MASK) !== '0) begin
            errors++; $display("FAIL empty_ctrl_mask: got v=%b c=%h exp v=0 masked bits 0", dn_if.valid, dn_if.ctrl);
        end
    endtask

    task automatic test_flush();
        dn_if.ready = 1'b0;
        push(DW'('h11));
        push(DW'('h22));
        checks++; if (up_if.ready !== 1'b0) begin errors++; $display("FAIL flush_full: got %b exp 0", up_if.ready); end
        flush = 1'b1;
        up_if.data = DW'('hDEAD);
        tick();
        flush = 1'b0;
        checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b exp 0", dn_if.valid); end
        checks++; if (up_if.ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b exp 1", up_if.ready); end
        checks++; if ((dn_if.ctrl & MASK) !== '0) begin errors++; $display("FAIL flush_ctrl_mask: got %h exp 0", dn_if.ctrl & MASK); end
        push(DW'('h33));
        flush = 1'b1;
        up_if.data = DW'('h44);
        tick();
        flush = 1'b0;
        up_if.valid = 1'b0;
        dn_if.ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL flush_dropped[%0d]: got v=%b d=%h exp v=0", k, dn_if.valid, dn_if.data); end
        end
    endtask

    task automatic test_saturate();
        dn_if.ready = 1'b0;
        push(DW'('h55));
        push(DW'('h66));
        rst = 1'b1;
        up_if.valid = 1'b0;
        tick();
        checks++; if (dn_if.valid !== 1'b0 || up_if.ready !== 1'b0) begin
            errors++; $display("FAIL midrst: got v=%b r=%b exp v=0 r=0", dn_if.valid, up_if.ready);
        end
        checks++; if (stall_cnt !== 16'd0 || stall_cnt4 !== 4'd0) begin
            errors++; $display("FAIL midrst_stall: got %0d/%0d exp 0/0", stall_cnt, stall_cnt4);
        end
        rst = 1'b0;
        tick();
        push(DW'('h77));
        up_if.valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++; if (stall_cnt4 !== sat4(cnt)) begin errors++; $display("FAIL sat_step[%0d]: got %0d exp %0d", k, stall_cnt4, sat4(cnt)); end
        end
        checks++; if (stall_cnt4 !== 4'hF) begin errors++; $display("FAIL sat_final: got %0d exp 15", stall_cnt4); end
        checks++; if (stall_cnt !== 16'd20) begin errors++; $display("FAIL sat_wide: got %0d exp 20", stall_cnt); end
        dn_if.ready = 1'b1;
        tick();
        tick();
        checks++; if (stall_cnt4 !== 4'hF) begin errors++; $display("FAIL sat_hold: got %0d exp 15", stall_cnt4); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            up_if.valid = $urandom_range(0, 3) != 0;
            up_if.data  = {$urandom, $urandom, $urandom};
            up_if.ctrl  = CW'($urandom);
            up_if.kill  = $urandom_range(0, 3) == 0;
            dn_if.ready = $urandom_range(0, 2) != 0;
            flush       = $urandom_range(0, 31) == 0;
            tick();
            checks++; if (dn_if.valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b exp %b", i, dn_if.valid, q.size() > 0); end
            checks++; if (up_if.ready !== m_rdy) begin errors++; $display("FAIL rnd_ready[%0d]: got %b exp %b", i, up_if.ready, m_rdy); end
            if (q.size() > 0) begin
                checks++; if (dn_if.data !== q[0].d) begin errors++; $display("FAIL rnd_data[%0d]: got %h exp %h", i, dn_if.data, q[0].d); end
                checks++; if (dn_if.ctrl !== q[0].c) begin errors++; $display("FAIL rnd_ctrl[%0d]: got %h exp %h", i, dn_if.ctrl, q[0].c); end
            end else begin
                checks++; if ((dn_if.ctrl & MASK) !== '0) begin errors++; $display("FAIL rnd_mask[%0d]: got %h exp 0", i, dn_if.ctrl & MASK); end
            end
            checks++; if (stall_cnt !== 16'(cnt)) begin errors++; $display("FAIL rnd_stall[%0d]: got %0d exp %0d", i, stall_cnt, cnt); end
            checks++; if (stall_cnt4 !== sat4(cnt)) begin errors++; $display("FAIL rnd_stall4[%0d]: got %0d exp %0d", i, stall_cnt4, sat4(cnt)); end
        end
        flush = 1'b0;
        up_if.valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_kill();
        test_flush();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised, elastic successor to the fixed ID/EX pipeline register. It carries one payload word per instruction: a datapath field and a control field. It provides a valid/ready handshake so a downstream stall does not have to be broadcast combinationally upstream, using a 2-entry skid buffer. It also supports a flush (squash everything in flight), a per-transfer kill that zeroes selected control bits to form a bubble, and a saturating stall-cycle counter. It is instantiated between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
DATA_W, 96, width of datapath payload (pc, operands, imm, register ids, ...).
CTRL_W, 16, width of control payload.
KILL_MASK, {CTRL_W{1'b1}}, control bits forced to 0 on kill and masked while out_valid=0.
CNT_W, 16, width of the stall counter.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
in_valid  in  1  upstream has a payload.
in_ready  out  1  stage can accept; registered; 0 while rst=1.
in_data  in  DATA_W  datapath payload.
in_ctrl  in  CTRL_W  control payload.
in_kill  in  1  zero KILL_MASK bits of in_ctrl on this transfer.
flush  in  1  discard all held entries and the current input.
out_valid  out  1  head entry valid.
out_ready  in  1  downstream accepts head.
out_data  out  DATA_W  head datapath payload.
out_ctrl  out  CTRL_W  head control; KILL_MASK bits gated by out_valid.
stall_cnt  out  CNT_W  saturating count of out_valid && !out_ready cycles.

Behaviour:
- Storage: main entry M (head) and skid entry S, each holding valid, data, and ctrl. in_ready = !S.valid, registered.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- Kill: the captured ctrl is in_ctrl & ~KILL_MASK when in_kill=1; data is captured unchanged.
- Update priority per cycle: rst > flush > normal.
- rst: M.valid=S.valid=0; all data/ctrl=0; stall_cnt=0; in_ready=0 during rst, 1 on the first cycle after.
- flush (rst=0): M.valid=S.valid=0 next cycle. The input is dropped even if in_fire. stall_cnt is not affected. The data/ctrl contents may stay stale, but they are masked by valid.
- Normal transitions (M,S valid): 
  - (0,0): on in_fire, load M.
  - (1,0): on out_fire with in_fire, replace M; on out_fire alone, M empties; on in_fire alone, load S.
  - (1,1): in_ready=0; on out_fire, S moves to M and S empties.
  - (0,1) is unreachable; the assertion checks this.
- Latency: 1 cycle from in_fire to out_valid when empty. Throughput is 1/cycle with no bubbles while out_ready=1.
- Ordering is strict FIFO. No payload is lost or duplicated except under flush.
- out_data = M.data. out_ctrl = M.ctrl with KILL_MASK bits forced to 0 when !M.valid, so a downstream stage never sees a write-enable from an empty slot.
- stall_cnt increments when out_valid & !out_ready and saturates at 2^CNT_W-1. It is cleared only by rst.
- in_ready depends only on registers; there is no combinational path from out_ready to in_ready. The out_* signals are purely registered, apart from the valid gating on out_ctrl.
- Reset mid-operation: all entries are discarded immediately, and no output fires in the reset cycle (out_valid=0 next edge).

Decomposition:
- Shared package pipe_pkg holds:
  - default DATA_W/CTRL_W per stage;
  - control-bit index constants (CTRL_MEM_WRITE, CTRL_REG_WRITE, CTRL_BRANCH, CTRL_JUMP, CTRL_HALT);
  - KILL_MASK constants per stage (ID/EX: mem_write|reg_write|branch|jump|halt).
- One sub-module: pipe_entry (valid+data+ctrl register with load and clear, built from dff), instantiated for M and S.

Test Plan:
- Reset with in_valid=1 -> in_ready=0, out_valid=0, stall_cnt=0 during rst; in_ready=1 the cycle after.
- Stream 0x1..0x8 with out_ready=1 -> out_data 0x1..0x8 on consecutive cycles, first one 1 cycle after the first in_fire, in_ready held at 1.
- out_ready=0 while pushing 0xA, 0xB, 0xC -> 0xA and 0xB accepted and in_ready=0; 0xC held upstream; stall_cnt increments each cycle. Release out_ready -> output order 0xA, 0xB, 0xC.
- in_kill=1 with in_ctrl=0xFFFF and the ID/EX mask -> out_ctrl has mem_write/reg_write/branch/jump/halt = 0 and the other bits = 1; out_data unchanged.
- Both entries full plus flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, out_ctrl masked bits = 0; the flushed input never appears.
- CNT_W=4, out_valid held with out_ready=0 for 20 cycles -> stall_cnt saturates at 15 and holds.
